// File: rtl/ctrl_proto_pkg.sv
// Shared definitions for the request/confirm register-load protocol.
package ctrl_proto_pkg;

    // Requester FSM states
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StData = 3'd2,
        StConf = 3'd3,
        StRel  = 3'd4,
        StGap  = 3'd5
    } state_t;

    // Destination register selected by the top bit of inputData
    localparam logic TARGET_P = 1'b0;
    localparam logic TARGET_Q = 1'b1;

    localparam int unsigned TARGET_BIT = 7;
    localparam int unsigned DATA_W     = 7;
    localparam int unsigned WORD_W     = 8;
    localparam int unsigned CNT_W      = 4;

    // Down-counter load value for a phase lasting 'cycles' cycles
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/req_fifo2.sv
// Two-entry synchronous FIFO; a push is dropped when full, even if popping.
module req_fifo2
    import ctrl_proto_pkg::*;
#(
    parameter int unsigned Width = WORD_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_pop,
    output logic [Width-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    logic [Width-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic w_do_push;
    logic w_do_pop;

    // Flags and gated handshakes
    always_comb begin
        o_full    = (r_count == 2'd2);
        o_empty   = (r_count == 2'd0);
        w_do_push = i_push && !o_full;
        w_do_pop  = i_pop && !o_empty;
        o_rdata   = r_mem[r_rptr];
    end

    // Storage, pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/controller_requester.sv
// Initiator of the request/confirm register-load protocol. Buffers host words
// and replays each as request -> data -> confirm, back-to-back when more work waits.
module controller_requester
    import ctrl_proto_pkg::*;
#(
    parameter int unsigned REQ_LEAD    = 1,
    parameter int unsigned DATA_SETUP  = 1,
    parameter int unsigned CONF_CYCLES = 1,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              send_valid,
    output logic              send_ready,
    input  logic              send_target,
    input  logic [DATA_W-1:0] send_data,
    output logic              request,
    output logic              confirm,
    output logic [WORD_W-1:0] inputData,
    output logic              busy,
    output logic              done,
    output logic [7:0]        txn_count
);

    localparam logic [CNT_W-1:0] LD_REQ  = cnt_load(REQ_LEAD);
    localparam logic [CNT_W-1:0] LD_DATA = cnt_load(DATA_SETUP);
    localparam logic [CNT_W-1:0] LD_CONF = cnt_load(CONF_CYCLES);
    localparam logic [CNT_W-1:0] LD_GAP  = cnt_load(GAP_CYCLES);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_request;
    logic              r_confirm;
    logic [WORD_W-1:0] r_data;
    logic              r_done;
    logic [7:0]        r_txn_count;

    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_cnt_zero;

    // Host word packing and FIFO pop decode
    always_comb begin
        w_word             = '0;
        w_word[TARGET_BIT] = send_target;
        w_word[DATA_W-1:0] = send_data;
        w_cnt_zero         = (r_cnt == '0);
        // Pop on the edge entering DATA, from REQ or straight from CONF
        w_pop = w_cnt_zero && ((r_state == StReq) || ((r_state == StConf) && !w_empty));
    end

    req_fifo2 #(
        .Width (WORD_W)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_push  (send_valid),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Protocol sequencer with registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_request   <= 1'b0;
            r_confirm   <= 1'b0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_txn_count <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        r_state   <= StReq;
                        r_cnt     <= LD_REQ;
                        r_request <= 1'b1;
                        r_data    <= '0;
                    end
                end
                StReq: begin
                    if (w_cnt_zero) begin
                        r_state <= StData;
                        r_cnt   <= LD_DATA;
                        r_data  <= w_head;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StData: begin
                    if (w_cnt_zero) begin
                        r_state   <= StConf;
                        r_cnt     <= LD_CONF;
                        r_confirm <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StConf: begin
                    if (w_cnt_zero) begin
                        r_confirm   <= 1'b0;
                        r_done      <= 1'b1;
                        r_txn_count <= r_txn_count + 8'd1;
                        if (!w_empty) begin
                            // Keep request high and present the next word
                            r_state <= StData;
                            r_cnt   <= LD_DATA;
                            r_data  <= w_head;
                        end else begin
                            // Drop request but hold data one more cycle
                            r_state   <= StRel;
                            r_cnt     <= '0;
                            r_request <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StRel: begin
                    r_state <= StGap;
                    r_cnt   <= LD_GAP;
                    r_data  <= '0;
                end
                StGap: begin
                    if (w_cnt_zero) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_cnt     <= '0;
                    r_request <= 1'b0;
                    r_confirm <= 1'b0;
                    r_data    <= '0;
                end
            endcase
        end
    end

    // Output drive
    always_comb begin
        send_ready = !w_full;
        busy       = (r_state != StIdle) || !w_empty;
        request    = r_request;
        confirm    = r_confirm;
        inputData  = r_data;
        done       = r_done;
        txn_count  = r_txn_count;
    end

endmodule

// File: doc/controller_requester.md
Name: controller_requester

Overview:
- Initiator side of the request/confirm register-load protocol. It generates `request`, `confirm` and `inputData[7:0]` towards `controller_and_register`.
- A host pushes {target, 7-bit value} words through a valid/ready port. The block buffers up to 2 words and replays each one as a protocol transaction: request high, data presented, confirm pulse.
- `inputData[7]` selects the destination register: 0 = P, 1 = Q. `inputData[6:0]` carries the value.

Parameters:
- REQ_LEAD, 1: cycles `request` is high with `inputData`=0 before data is presented (1..15).
- DATA_SETUP, 1: cycles data is stable before `confirm` rises (1..15).
- CONF_CYCLES, 1: width of the `confirm` pulse in cycles (1..15).
- GAP_CYCLES, 1: idle cycles after release before the next transaction starts (1..15).

Ports:
- clock, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- send_valid, input, 1: host word valid.
- send_ready, output, 1: FIFO not full; a word is accepted when valid&&ready.
- send_target, input, 1: 0 = P, 1 = Q.
- send_data, input, 7: value to load.
- request, output, 1: protocol request.
- confirm, output, 1: protocol confirm strobe.
- inputData, output, 8: {target, data} while a transaction is active, else 0.
- busy, output, 1: state != IDLE or FIFO non-empty.
- done, output, 1: one-cycle pulse per completed transaction.
- txn_count, output, 8: completed transactions, wraps 255 -> 0.

Behaviour:
- Reset (async, reset_n=0):
  - request=0, confirm=0, inputData=0, done=0, busy=0, txn_count=0.
  - FIFO flushed; send_ready=1.
  - State forced to IDLE immediately, also mid-transaction.
- FIFO:
  - 2 entries of 8 bits, registered.
  - send_ready = !full. There is no push-through when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are legal when not full; occupancy is unchanged.
- FSM states: IDLE, REQ, DATA, CONF, REL, GAP. One down-counter (4 bits) is loaded on each state entry.
- IDLE:
  - Outputs 0.
  - FIFO non-empty -> REQ next edge.
- REQ:
  - request=1, inputData=0, held for REQ_LEAD cycles.
  - Then -> DATA, popping the FIFO head into the output register on the transition edge.
- DATA:
  - request=1, inputData=popped word, confirm=0, for DATA_SETUP cycles.
  - Then -> CONF.
- CONF:
  - request=1, confirm=1, inputData held, for CONF_CYCLES cycles.
  - Exit rule:
    - FIFO non-empty: back-to-back. request stays 1, go directly to DATA, pop the next word, increment txn_count and pulse done on that edge.
    - FIFO empty: -> REL.
- REL (1 cycle):
  - request=0, confirm=0, inputData still holds the word (hold time).
  - done=1, txn_count+1.
  - Then -> GAP.
- GAP:
  - All protocol outputs 0, for GAP_CYCLES cycles.
  - Then -> IDLE.
- Default timing (all parameters = 1), word pushed at edge 0 into an empty FIFO:
  - cycle 1: IDLE.
  - cycle 2: request=1.
  - cycle 3: inputData valid.
  - cycle 4: confirm=1.
  - cycle 5: request=0, done=1.
  - cycle 6: GAP.
  - cycle 7: IDLE.
- Invariants:
  - confirm is never high while request is low.
  - inputData never changes while confirm=1.
- Host input: changes on send_* while not accepted are ignored. Data is captured only on the accepting edge.

Decomposition:
- Shared package `ctrl_proto_pkg`:
  - state encoding constants.
  - TARGET_P=0, TARGET_Q=1.
  - the target bit index (7).
  - data width (7).
- One sub-module, `req_fifo2`: a 2-entry synchronous FIFO with async active-low reset and full/empty flags.
- The FSM, timing counter and txn_count live in `controller_requester`.

Test Plan:
- Single word, defaults: push target=1, data=7'h03 at edge 0.
  - request rises at cycle 2; inputData=8'h83 from cycle 3; confirm=1 in cycle 4 only.
  - request=0 and done=1 in cycle 5; txn_count=1; busy=0 from cycle 7.
- Back-to-back: push 8'h63 (P, 7'h63) then 8'hE3 (Q, 7'h63) on consecutive edges.
  - request stays high across both transactions, with two confirm pulses.
  - inputData goes 8'h63 -> 8'hE3; done pulses twice; txn_count=2.
- Full FIFO: hold send_valid=1 for 4 edges while idle.
  - Exactly 3 words accepted: 2 buffered plus 1 popped at DATA entry.
  - send_ready=0 while 2 are buffered; no word lost or duplicated.
- Parameters REQ_LEAD=3, DATA_SETUP=2, CONF_CYCLES=4: confirm asserts 5 cycles after request rises, stays high exactly 4 cycles, and data is stable throughout.
- Reset mid-CONF: drop reset_n asynchronously.
  - request, confirm and inputData go to 0 without waiting for a clock edge; FIFO is emptied; txn_count=0.
  - After release the block accepts a new word normally.
- Counter wrap: 256 transactions -> txn_count returns to 0 and done has pulsed 256 times.
